// File: rtl/wb_select_seq.sv
// Sequential writeback selector: waits for the chosen source, registers its word, strobes one write.
// Bad selectors write 0 with sel_err; a source silent for TIMEOUT WAIT cycles aborts with timeout_err.
module wb_select_seq #(
   parameter int W       = 32,
   parameter int N       = 5,
   parameter int SELW    = 4,
   parameter int RW      = 5,
   parameter int TIMEOUT = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            wb_req,
   input  logic [SELW-1:0] wb_sel,
   input  logic [RW-1:0]   wb_rd,
   input  logic [N*W-1:0]  src_data,
   input  logic [N-1:0]    src_ready,
   output logic            busy,
   output logic            reg_write,
   output logic [RW-1:0]   rd_out,
   output logic [W-1:0]    data_out,
   output logic            sel_err,
   output logic            timeout_err,
   output logic            req_drop
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]   TO_L = CW'(TIMEOUT);
   localparam logic [SELW:0]   N_L  = (SELW + 1)'(N);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE} state_t;

   state_t          state_q, state_d;
   logic [SELW-1:0] sel_q, sel_d;
   logic [RW-1:0]   rd_q, rd_d;
   logic [W-1:0]    data_q, data_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            sel_err_q, sel_err_d;
   logic            timeout_err_q, timeout_err_d;
   logic            req_drop_q, req_drop_d;

   logic            sel_bad, req_rdy, wait_rdy, expire;
   logic [W-1:0]    req_dat, wait_dat;

   // Decoded muxes keep out-of-range selectors from indexing past the source array.
   always_comb begin
      req_rdy  = 1'b0;
      req_dat  = '0;
      wait_rdy = 1'b0;
      wait_dat = '0;
      for (int i = 0; i < N; i++) begin
         if (wb_sel == SELW'(i)) begin
            req_rdy = src_ready[i];
            req_dat = src_data[i*W +: W];
         end
         if (sel_q == SELW'(i)) begin
            wait_rdy = src_ready[i];
            wait_dat = src_data[i*W +: W];
         end
      end
   end

   assign sel_bad = ({1'b0, wb_sel} >= N_L);
   assign expire  = (TIMEOUT != 0) && (cnt_q == CW'(1)) && !wait_rdy;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (wb_req) state_d = (sel_bad || req_rdy) ? S_WRITE : S_WAIT;
         S_WAIT:  if (wait_rdy) state_d = S_WRITE;
                  else if (expire) state_d = S_IDLE;
         S_WRITE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      busy      = (state_q != S_IDLE);
      reg_write = (state_q == S_WRITE);
   end

   always_comb begin
      sel_d         = sel_q;
      rd_d          = rd_q;
      data_d        = data_q;
      cnt_d         = cnt_q;
      sel_err_d     = 1'b0;
      timeout_err_d = 1'b0;
      req_drop_d    = wb_req && (state_q != S_IDLE);
      case (state_q)
         S_IDLE: if (wb_req) begin
            sel_d = wb_sel;
            rd_d  = wb_rd;
            if (sel_bad) begin
               data_d    = '0;
               sel_err_d = 1'b1;
            end else if (req_rdy) begin
               data_d = req_dat;
            end else begin
               cnt_d = TO_L;
            end
         end
         S_WAIT: begin
            if (wait_rdy) begin
               data_d = wait_dat;
            end else if (expire) begin
               timeout_err_d = 1'b1;
            end else if (TIMEOUT != 0) begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sel_q         <= '0;
         rd_q          <= '0;
         data_q        <= '0;
         cnt_q         <= '0;
         sel_err_q     <= 1'b0;
         timeout_err_q <= 1'b0;
         req_drop_q    <= 1'b0;
      end else begin
         sel_q         <= sel_d;
         rd_q          <= rd_d;
         data_q        <= data_d;
         cnt_q         <= cnt_d;
         sel_err_q     <= sel_err_d;
         timeout_err_q <= timeout_err_d;
         req_drop_q    <= req_drop_d;
      end
   end

   assign rd_out      = rd_q;
   assign data_out    = data_q;
   assign sel_err     = sel_err_q;
   assign timeout_err = timeout_err_q;
   assign req_drop    = req_drop_q;

endmodule

// File: doc/wb_select_seq.md
# wb_select_seq

Parametrised, sequential writeback-source selector for the multicycle datapath. It accepts a writeback request naming a source (ALU, Hi, Lo, shifter, SLT, and future sources) and a destination register, then waits for that source to signal ready. It registers the selected word and issues a single-cycle register-file write strobe. Out-of-range selectors and sources that never become ready are flagged rather than silently written.

## Interface
- `W`, 32: data width of every source and of `data_out`.
- `N`, 5: number of sources; source i occupies `src_data[i*W +: W]`.
- `SELW`, 4: selector width; must satisfy 2^SELW >= N.
- `RW`, 5: destination register index width.
- `TIMEOUT`, 64: maximum WAIT cycles; 0 = wait indefinitely.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `wb_req`  in  1  writeback request, sampled only in IDLE.
- `wb_sel`  in  SELW  source index for the request.
- `wb_rd`  in  RW  destination register index for the request.
- `src_data`  in  N*W  flattened source words.
- `src_ready`  in  N  per-source data-valid flags; bit i qualifies source i.
- `busy`  out  1  high whenever state is not IDLE.
- `reg_write`  out  1  one-cycle register-file write strobe.
- `rd_out`  out  RW  destination index, valid while `reg_write`=1.
- `data_out`  out  W  written word, valid while `reg_write`=1.
- `sel_err`  out  1  one-cycle pulse: the request had `wb_sel` >= N.
- `timeout_err`  out  1  one-cycle pulse: the source was not ready within TIMEOUT cycles.
- `req_drop`  out  1  one-cycle pulse: `wb_req` arrived while busy and was ignored.

## Operation
- States: IDLE, WAIT, WRITE.
- IDLE, `wb_req`=1: latch `wb_sel` into `sel_q` and `wb_rd` into `rd_out`.
  - `wb_sel` >= N: load `data_out` with 0, pulse `sel_err` next cycle, go to WRITE. The write still occurs, storing 0.
  - `src_ready[wb_sel]`=1: load `data_out` with `src_data[wb_sel]`, go to WRITE.
  - Otherwise: load the counter with TIMEOUT, go to WAIT.
- WAIT, each cycle:
  - `src_ready[sel_q]`=1: capture its data, go to WRITE. Ready takes priority over timeout in the same cycle.
  - Otherwise, if TIMEOUT != 0 and counter == 1: go to IDLE, pulse `timeout_err` next cycle, no write.
  - Otherwise: decrement the counter (no decrement when TIMEOUT=0).
- WRITE: `reg_write`=1 for exactly this cycle; unconditionally return to IDLE.
- `wb_req`=1 in WAIT or WRITE: ignored, `req_drop` pulses next cycle. State and latched values are unchanged.
- `data_out` and `rd_out` hold their last values outside WRITE. Consumers must qualify them with `reg_write`.
- Source data is sampled only at the capture edge; later changes to `src_data` do not affect the write.

## Timing
- Reset (asynchronous, `reset`=0):
  - state = IDLE, counter = 0.
  - `busy`, `reg_write`, `sel_err`, `timeout_err`, `req_drop` = 0.
  - `data_out` = 0, `rd_out` = 0.
- Reset asserted mid-WAIT or mid-WRITE aborts immediately; no write strobe follows deassertion.
- Latency with ready source: request at edge n, `reg_write` high in cycle n+1.
- Latency with late source: ready first seen at edge m, `reg_write` high in cycle m+1.
- Timeout: with no ready, `timeout_err` is high in cycle n+TIMEOUT+1; `busy` is low in that same cycle.
- Back-to-back: a new request is accepted in the first IDLE cycle after WRITE. Minimum spacing between writes is 2 cycles.
- All outputs are registered or decoded from state; no combinational path from any input to any output.

## Test plan
- Reset mid-WAIT: assert `reset`=0 while in WAIT -> all outputs 0 immediately; no `reg_write` after release.
- ALU path: `src_data` slot0=0x0000_00AA, `src_ready`=5'b00001, req sel=0, rd=9 -> next cycle `reg_write`=1, `data_out`=0x0000_00AA, `rd_out`=9; following cycle `reg_write`=0, `busy`=0.
- Late Hi: req sel=1, `src_ready[1]`=0, raised after 3 cycles with value 0xDEAD_BEEF -> `reg_write` once, 1 cycle after ready, `data_out`=0xDEAD_BEEF; `busy` high throughout.
- Timeout: TIMEOUT=4, req sel=2, never ready -> `timeout_err` pulses in cycle req+5; no `reg_write`; next request accepted.
- Bad selector: req sel=7 with N=5 -> `sel_err`=1 and `reg_write`=1 with `data_out`=0 in the same cycle.
- Drop: second `wb_req` issued during WAIT -> `req_drop` pulses 1 cycle; the original transaction completes with its original `rd_out`.
